// File: rtl/apb_cmd_master_if.sv
// Command/response and APB bus bundle for apb_cmd_master.
// The master modport is the apb_cmd_master view; the slave modport is the controller plus APB slaves.
interface apb_cmd_master_if #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int SEL_BITS   = $clog2(NUM_SLAVES)
);
  logic                             i_cmd_valid;
  logic                             o_cmd_ready;
  logic                             i_cmd_wr;
  logic [SEL_BITS-1:0]              i_cmd_slave;
  logic [ADDR_WIDTH-1:0]            i_cmd_addr;
  logic [DATA_WIDTH-1:0]            i_cmd_wdata;
  logic                             o_rsp_valid;
  logic                             i_rsp_ready;
  logic [DATA_WIDTH-1:0]            o_rsp_rdata;
  logic [1:0]                       o_rsp_err;
  logic                             o_busy;
  logic [ADDR_WIDTH-1:0]            o_PADDR;
  logic [NUM_SLAVES-1:0]            o_PSEL;
  logic                             o_PENABLE;
  logic                             o_PWRITE;
  logic [DATA_WIDTH-1:0]            o_PWDATA;
  logic [NUM_SLAVES-1:0]            i_PREADY;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] i_PRDATA;
  logic [NUM_SLAVES-1:0]            i_PSLVERR;

  modport master (
    input  i_cmd_valid, i_cmd_wr, i_cmd_slave, i_cmd_addr, i_cmd_wdata, i_rsp_ready,
    input  i_PREADY, i_PRDATA, i_PSLVERR,
    output o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_busy,
    output o_PADDR, o_PSEL, o_PENABLE, o_PWRITE, o_PWDATA
  );

  modport slave (
    output i_cmd_valid, i_cmd_wr, i_cmd_slave, i_cmd_addr, i_cmd_wdata, i_rsp_ready,
    output i_PREADY, i_PRDATA, i_PSLVERR,
    input  o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_busy,
    input  o_PADDR, o_PSEL, o_PENABLE, o_PWRITE, o_PWDATA
  );
endinterface

// File: rtl/apb_cmd_master.sv
// APB master with command/response front end and built-in N-slave response mux.
// Optional ACCESS timeout abort enabled by defining APB_CMD_MASTER_TIMEOUT_EN.
module apb_cmd_master #(
  parameter int NUM_SLAVES     = 4,
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int SEL_BITS       = $clog2(NUM_SLAVES),
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic                i_PCLK,
  input logic                i_PRESET,
  apb_cmd_master_if.master   io_bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_wr;
  logic [SEL_BITS-1:0]   r_slave;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_err;

  logic                  w_accept;
  logic                  w_in_range;
  logic                  w_done;
  logic                  w_timeout;
  logic                  w_sel_ready;
  logic                  w_sel_err;
  logic [DATA_WIDTH-1:0] w_sel_rdata;
  logic [NUM_SLAVES-1:0] w_onehot;

  logic                  w_cmd_ready;
  logic                  w_rsp_valid;
  logic                  w_busy;
  logic                  w_penable;
  logic [NUM_SLAVES-1:0] w_psel;

  assign w_accept   = (r_state == S_IDLE) && io_bus.i_cmd_valid;
  assign w_in_range = ({1'b0, io_bus.i_cmd_slave} < (SEL_BITS+1)'(NUM_SLAVES));
  assign w_done     = (r_state == S_ACCESS) && w_sel_ready;

  // Decode the registered slave index and mux only that slave's response.
  always_comb begin
    w_onehot    = '0;
    w_sel_ready = 1'b0;
    w_sel_err   = 1'b0;
    w_sel_rdata = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      w_onehot[k] = (r_slave == SEL_BITS'(k));
      w_sel_ready = w_sel_ready | (w_onehot[k] & io_bus.i_PREADY[k]);
      w_sel_err   = w_sel_err | (w_onehot[k] & io_bus.i_PSLVERR[k]);
      w_sel_rdata = w_sel_rdata
                  | ({DATA_WIDTH{w_onehot[k]}} & io_bus.i_PRDATA[k*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_to_cnt;

  // Wait-cycle counter; saturates at the limit, where PREADY still wins.
  always_ff @(posedge i_PCLK or posedge i_PRESET) begin
    if (i_PRESET) begin
      r_to_cnt <= '0;
    end else if (r_state == S_SETUP) begin
      r_to_cnt <= '0;
    end else if ((r_state == S_ACCESS) && !w_sel_ready
                 && (r_to_cnt != TO_W'(TIMEOUT_CYCLES))) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end else begin
      r_to_cnt <= r_to_cnt;
    end
  end

  assign w_timeout = (r_state == S_ACCESS) && !w_sel_ready
                   && (r_to_cnt == TO_W'(TIMEOUT_CYCLES));
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_PCLK or posedge i_PRESET) begin
    if (i_PRESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = w_in_range ? S_SETUP : S_RESP;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_SETUP:  w_next = S_ACCESS;
      S_ACCESS: begin
        if (w_done || w_timeout) begin
          w_next = S_RESP;
        end else begin
          w_next = S_ACCESS;
        end
      end
      S_RESP: begin
        if (io_bus.i_rsp_ready) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_RESP;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Command capture and response latch; bus fields keep their last value while idle.
  always_ff @(posedge i_PCLK or posedge i_PRESET) begin
    if (i_PRESET) begin
      r_wr    <= 1'b0;
      r_slave <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 2'b00;
    end else if (w_accept) begin
      r_wr    <= io_bus.i_cmd_wr;
      r_slave <= io_bus.i_cmd_slave;
      r_addr  <= io_bus.i_cmd_addr;
      r_wdata <= io_bus.i_cmd_wdata;
      if (!w_in_range) begin
        r_err   <= 2'b11;
        r_rdata <= '0;
      end
    end else if (w_done) begin
      r_err   <= w_sel_err ? 2'b01 : 2'b00;
      r_rdata <= (!r_wr && !w_sel_err) ? w_sel_rdata : '0;
    end else if (w_timeout) begin
      r_err   <= 2'b10;
      r_rdata <= '0;
    end
  end

  // Output decode from the current state; cmd_ready is masked while reset is held.
  always_comb begin
    w_cmd_ready = 1'b0;
    w_rsp_valid = 1'b0;
    w_busy      = 1'b0;
    w_penable   = 1'b0;
    w_psel      = '0;
    case (r_state)
      S_IDLE: begin
        w_cmd_ready = !i_PRESET;
      end
      S_SETUP: begin
        w_psel = w_onehot;
        w_busy = 1'b1;
      end
      S_ACCESS: begin
        w_psel    = w_onehot;
        w_penable = 1'b1;
        w_busy    = 1'b1;
      end
      S_RESP: begin
        w_rsp_valid = 1'b1;
        w_busy      = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  assign io_bus.o_cmd_ready = w_cmd_ready;
  assign io_bus.o_rsp_valid = w_rsp_valid;
  assign io_bus.o_rsp_rdata = r_rdata;
  assign io_bus.o_rsp_err   = r_err;
  assign io_bus.o_busy      = w_busy;
  assign io_bus.o_PADDR     = r_addr;
  assign io_bus.o_PSEL      = w_psel;
  assign io_bus.o_PENABLE   = w_penable;
  assign io_bus.o_PWRITE    = r_wr;
  assign io_bus.o_PWDATA    = r_wdata;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master: directed and random transfers against a response model.
// Timeout cases follow APB_CMD_MASTER_TIMEOUT_EN when the bench is compiled with it.
module tb_apb_cmd_master;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  apb_cmd_master_if #(.NUM_SLAVES(4)) bus4 ();
  apb_cmd_master_if #(.NUM_SLAVES(3)) bus3 ();

  apb_cmd_master #(.NUM_SLAVES(4), .TIMEOUT_CYCLES(TO)) u_dut4 (
    .i_PCLK(clk), .i_PRESET(rst), .io_bus(bus4.master)
  );
  apb_cmd_master #(.NUM_SLAVES(3), .TIMEOUT_CYCLES(TO)) u_dut3 (
    .i_PCLK(clk), .i_PRESET(rst), .io_bus(bus3.master)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: number of PENABLE cycles for a transfer whose slave waits 'waits' cycles.
  function automatic int exp_en_cycles(input int waits);
`ifdef APB_CMD_MASTER_TIMEOUT_EN
    return (waits > TO) ? TO + 1 : waits + 1;
`else
    return waits + 1;
`endif
  endfunction

  function automatic logic [1:0] exp_err(input int waits, input bit slverr);
    if (exp_en_cycles(waits) < waits + 1) return 2'b10;
    return slverr ? 2'b01 : 2'b00;
  endfunction

  function automatic logic [15:0] exp_rdata(input bit wr, input logic [1:0] err,
                                            input logic [15:0] prdata);
    return (!wr && err == 2'b00) ? prdata : 16'h0000;
  endfunction

  // Unselected slaves look ready and erroring with random data; all must be ignored.
  task automatic drive_others(input int slave);
    for (int k = 0; k < 4; k++) begin
      if (k != slave) begin
        bus4.i_PREADY[k]          = 1'b1;
        bus4.i_PSLVERR[k]         = 1'b1;
        bus4.i_PRDATA[k*16 +: 16] = 16'($urandom);
      end
    end
  endtask

  task automatic do_txn(input bit wr, input int slave, input logic [15:0] addr,
                        input logic [15:0] wdata, input int waits, input bit slverr,
                        input logic [15:0] prdata, input int rsp_delay);
    logic [3:0]  onehot;
    logic [1:0]  e_err;
    logic [15:0] e_rd;
    int          en;
    onehot = 4'b0001 << slave;
    e_err  = exp_err(waits, slverr);
    e_rd   = exp_rdata(wr, e_err, prdata);
    en     = 0;
    chk("idle_cmd_ready", bus4.o_cmd_ready, 1);
    bus4.i_cmd_valid              = 1'b1;
    bus4.i_cmd_wr                 = wr;
    bus4.i_cmd_slave              = 2'(slave);
    bus4.i_cmd_addr               = addr;
    bus4.i_cmd_wdata              = wdata;
    bus4.i_PREADY[slave]          = 1'b0;
    bus4.i_PSLVERR[slave]         = slverr;
    bus4.i_PRDATA[slave*16 +: 16] = prdata;
    drive_others(slave);
    tick();
    bus4.i_cmd_valid = 1'b0;
    bus4.i_cmd_wr    = ~wr;
    bus4.i_cmd_addr  = 16'($urandom);
    bus4.i_cmd_wdata = 16'($urandom);
    chk("setup_psel", bus4.o_PSEL, onehot);
    chk("setup_penable", bus4.o_PENABLE, 0);
    chk("setup_paddr", bus4.o_PADDR, addr);
    chk("setup_pwrite", bus4.o_PWRITE, wr);
    chk("setup_pwdata", bus4.o_PWDATA, wdata);
    chk("setup_busy", bus4.o_busy, 1);
    chk("setup_cmd_ready", bus4.o_cmd_ready, 0);
    chk("setup_rsp_valid", bus4.o_rsp_valid, 0);
    for (int c = 0; c < 200; c++) begin
      drive_others(slave);
      tick();
      if (bus4.o_PENABLE !== 1'b1) break;
      en++;
      chk("access_psel", bus4.o_PSEL, onehot);
      chk("access_paddr", bus4.o_PADDR, addr);
      chk("access_pwdata", bus4.o_PWDATA, wdata);
      chk("access_rsp_valid", bus4.o_rsp_valid, 0);
      bus4.i_PREADY[slave] = (en == waits + 1);
    end
    bus4.i_PREADY[slave] = 1'b0;
    chk("en_cycles", en, exp_en_cycles(waits));
    chk("resp_psel", bus4.o_PSEL, 0);
    chk("resp_valid", bus4.o_rsp_valid, 1);
    chk("resp_err", bus4.o_rsp_err, e_err);
    chk("resp_rdata", bus4.o_rsp_rdata, e_rd);
    chk("resp_cmd_ready", bus4.o_cmd_ready, 0);
    chk("resp_busy", bus4.o_busy, 1);
    for (int d = 0; d < rsp_delay; d++) begin
      tick();
      chk("hold_valid", bus4.o_rsp_valid, 1);
      chk("hold_err", bus4.o_rsp_err, e_err);
      chk("hold_rdata", bus4.o_rsp_rdata, e_rd);
      chk("hold_cmd_ready", bus4.o_cmd_ready, 0);
    end
    bus4.i_rsp_ready = 1'b1;
    tick();
    bus4.i_rsp_ready = 1'b0;
    chk("done_rsp_valid", bus4.o_rsp_valid, 0);
    chk("done_busy", bus4.o_busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus4.i_cmd_valid = 1'b0; bus4.i_cmd_wr = 1'b0; bus4.i_cmd_slave = 2'd0;
    bus4.i_cmd_addr = 16'h0; bus4.i_cmd_wdata = 16'h0; bus4.i_rsp_ready = 1'b0;
    bus4.i_PREADY = 4'h0; bus4.i_PRDATA = 64'h0; bus4.i_PSLVERR = 4'h0;
    bus3.i_cmd_valid = 1'b0; bus3.i_cmd_wr = 1'b0; bus3.i_cmd_slave = 2'd0;
    bus3.i_cmd_addr = 16'h0; bus3.i_cmd_wdata = 16'h0; bus3.i_rsp_ready = 1'b0;
    bus3.i_PREADY = 3'b111; bus3.i_PRDATA = 48'h1111_2222_3333; bus3.i_PSLVERR = 3'b000;
    tick();
    tick();
    chk("rst_cmd_ready", bus4.o_cmd_ready, 0);
    chk("rst_rsp_valid", bus4.o_rsp_valid, 0);
    chk("rst_psel", bus4.o_PSEL, 0);
    chk("rst_penable", bus4.o_PENABLE, 0);
    chk("rst_busy", bus4.o_busy, 0);
    chk("rst_paddr", bus4.o_PADDR, 0);
    chk("rst_pwdata", bus4.o_PWDATA, 0);
    chk("rst_rsp_err", bus4.o_rsp_err, 0);
    chk("rst_rsp_rdata", bus4.o_rsp_rdata, 0);
    rst = 1'b0;
    tick();

    do_txn(1'b0, 2, 16'h0040, 16'h0000, 0, 1'b0, 16'hBEEF, 0);
    do_txn(1'b1, 1, 16'h0012, 16'h1234, 3, 1'b0, 16'h5555, 0);
    do_txn(1'b0, 0, 16'h0100, 16'h0000, 0, 1'b1, 16'hFFFF, 0);
    do_txn(1'b0, 3, 16'h0200, 16'h0000, 1, 1'b0, 16'hA5A5, 5);
`ifdef APB_CMD_MASTER_TIMEOUT_EN
    do_txn(1'b0, 1, 16'h0300, 16'h0000, TO, 1'b0, 16'hC0DE, 0);
    do_txn(1'b1, 2, 16'h0304, 16'h7777, 1000, 1'b0, 16'hDEAD, 1);
`endif
    for (int i = 0; i < 24; i++) begin
      do_txn(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 16'($urandom),
             16'($urandom), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
             16'($urandom), int'($urandom_range(0, 3)));
    end

    // Reset asserted between edges while the slave never answers.
    bus4.i_PREADY    = 4'h0;
    bus4.i_cmd_valid = 1'b1;
    bus4.i_cmd_slave = 2'd2;
    tick();
    bus4.i_cmd_valid = 1'b0;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
    repeat (3) tick();
`else
    repeat (100) tick();
`endif
    chk("stuck_penable", bus4.o_PENABLE, 1);
    chk("stuck_busy", bus4.o_busy, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("async_psel", bus4.o_PSEL, 0);
    chk("async_penable", bus4.o_PENABLE, 0);
    chk("async_busy", bus4.o_busy, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_rsp_valid", bus4.o_rsp_valid, 0);
      chk("post_rst_cmd_ready", bus4.o_cmd_ready, 1);
    end

    // Out-of-range slave on the three-slave instance.
    chk("dec_cmd_ready", bus3.o_cmd_ready, 1);
    bus3.i_cmd_valid = 1'b1;
    bus3.i_cmd_slave = 2'd3;
    bus3.i_cmd_addr  = 16'h0ABC;
    tick();
    bus3.i_cmd_valid = 1'b0;
    chk("dec_psel", bus3.o_PSEL, 0);
    chk("dec_rsp_valid", bus3.o_rsp_valid, 1);
    chk("dec_err", bus3.o_rsp_err, 2'b11);
    chk("dec_rdata", bus3.o_rsp_rdata, 0);
    chk("dec_busy", bus3.o_busy, 1);
    bus3.i_rsp_ready = 1'b1;
    tick();
    bus3.i_rsp_ready = 1'b0;
    chk("dec_done_valid", bus3.o_rsp_valid, 0);
    chk("dec_done_psel", bus3.o_PSEL, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
- Parametrised APB master with a command/response front end and a built-in N-slave response mux.
- Successor to the fixed two-slave master+arbiter pairing; it absorbs slave selection, PREADY/PRDATA/PSLVERR muxing, decode-error and timeout handling.
- Sits between a controller (memory-driven sequencer) and NUM_SLAVES APB slaves on one PCLK domain.

Parameters:
- NUM_SLAVES, 4, number of APB slaves (>=2).
- ADDR_WIDTH, 16, PADDR width.
- DATA_WIDTH, 16, PWDATA/PRDATA width.
- SEL_BITS, $clog2(NUM_SLAVES), command slave-index width (derived; not overridden).
- TIMEOUT_CYCLES, 16, maximum ACCESS wait cycles before abort (used only with APB_CMD_MASTER_TIMEOUT_EN).

Ports:
- i_PCLK  in  1  clock; all logic on rising edge
- i_PRESET  in  1  reset; one clock, asynchronous, active-high
- i_cmd_valid  in  1  command offered
- o_cmd_ready  out  1  command accepted when valid&ready
- i_cmd_wr  in  1  1=write, 0=read
- i_cmd_slave  in  SEL_BITS  target slave index
- i_cmd_addr  in  ADDR_WIDTH  transfer address
- i_cmd_wdata  in  DATA_WIDTH  write data
- o_rsp_valid  out  1  response available
- i_rsp_ready  in  1  response consumed when valid&ready
- o_rsp_rdata  out  DATA_WIDTH  read data (0 for writes/errors)
- o_rsp_err  out  2  00 OK, 01 SLVERR, 10 TIMEOUT, 11 DECERR
- o_busy  out  1  state != IDLE
- o_PADDR  out  ADDR_WIDTH  APB address
- o_PSEL  out  NUM_SLAVES  one-hot select
- o_PENABLE  out  1  APB enable
- o_PWRITE  out  1  APB direction
- o_PWDATA  out  DATA_WIDTH  APB write data
- i_PREADY  in  NUM_SLAVES  per-slave ready
- i_PRDATA  in  NUM_SLAVES*DATA_WIDTH  per-slave read data, slave k at [k*DATA_WIDTH +: DATA_WIDTH]
- i_PSLVERR  in  NUM_SLAVES  per-slave error

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0. Assertion mid-transfer drops PSEL/PENABLE immediately (async); the pending command is lost and no response is issued.
- FSM: IDLE, SETUP, ACCESS, RESP.
- IDLE: o_cmd_ready=1. On valid&ready, register wr/slave/addr/wdata.
  - slave < NUM_SLAVES: next state SETUP.
  - otherwise: next state RESP with err=11, rdata=0, no PSEL asserted.
- SETUP (exactly 1 cycle): o_PSEL[slave]=1, o_PENABLE=0; PADDR/PWRITE/PWDATA driven from the registered command.
- ACCESS: o_PENABLE=1; PSEL/PADDR/PWRITE/PWDATA held stable.
  - Only the selected slave's PREADY/PRDATA/PSLVERR are observed; other slaves' inputs are ignored.
  - PREADY=1: sample PSLVERR and PRDATA; next state RESP; PSEL and PENABLE return to 0 the following cycle.
  - Response data: err=01 if PSLVERR else 00; rdata=PRDATA only for an error-free read, else 0.
- RESP: o_rsp_valid=1, rdata/err held until i_rsp_ready=1, then IDLE.
  - o_cmd_ready=0 in every state except IDLE; there is no command/response overlap.
- Latency: command accepted at edge T0; SETUP visible T0..T1; ACCESS from T1. With zero wait states, o_rsp_valid rises after T2. Minimum command-to-command spacing is 4 cycles.
- In IDLE/RESP: PADDR/PWRITE/PWDATA retain their last values; PSEL=0, PENABLE=0.
- o_busy=1 in SETUP, ACCESS and RESP.

Optional Feature:
- Macro APB_CMD_MASTER_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When it reaches TIMEOUT_CYCLES with PREADY still 0, the transfer aborts: PSEL/PENABLE drop next cycle, RESP with err=10, rdata=0.
  - If PREADY=1 in the same cycle the count reaches the limit, the transfer completes normally (PREADY wins).
- Undefined: no counter; ACCESS waits indefinitely; err=10 is never produced.

Test Plan:
- Read, slave 2, addr 0x0040, PRDATA[2]=0xBEEF, PREADY[2]=1 first ACCESS cycle -> PSEL=4'b0100 for 2 cycles; rsp_valid 3 cycles after accept; rdata=0xBEEF, err=00.
- Write, slave 1, addr 0x0012, wdata 0x1234, PREADY[1] low 3 ACCESS cycles -> PENABLE high 4 cycles; PWDATA stable throughout; rdata=0, err=00; PREADY[0]=1 during the waits is ignored.
- Read, slave 0, PSLVERR[0]=1 with PREADY[0]=1, PRDATA=0xFFFF -> err=01, rdata=0.
- NUM_SLAVES=3, slave index 3 -> no PSEL bit ever set; err=11 one cycle after accept.
- Macro defined, TIMEOUT_CYCLES=16, PREADY held 0 -> abort after 16 wait cycles, err=10, PSEL=0. Macro undefined -> still in ACCESS after 100 cycles.
- i_rsp_ready=0 for 5 cycles -> rsp_valid/rdata/err stable and o_cmd_ready=0. Separately, i_PRESET asserted mid-ACCESS -> PSEL/PENABLE/o_busy go 0 before the next edge and no response is issued.
